bg_read_arbiter: RTL and testbench

- Shares the single registered read port of the background palette-index RAM (4-bit entries, 17-bit address, 480x270 = 129600 entries) between two requesters.
- Requester 0 is the VGA display fetch path. It has priority and cannot stall.
- Requester 1 is the game-logic collision probe. It uses a req/ack handshake.
- The block converts (x, y) coordinates to linear addresses, tags in-flight reads, returns data with 2-cycle latency, and guarantees the probe cannot be starved.

---
 rtl/bg_read_arbiter.sv | 133 +++++++++++++
 tb/tb_bg_read_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bg_read_arbiter.sv
// bg_read_arbiter
//   Shares the single registered read port of the background palette-index
//   RAM between the display fetch path (priority, never stalls) and the
//   collision probe (req/ack handshake). Converts (x, y) into a linear
//   address, tags every issue, and returns data two cycles after issue.
//   A probe refused STARVE_LIMIT-1 cycles in a row is granted on the next
//   cycle even over a display request; the displaced display request is
//   still answered on time, with the last served display value marked stale.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   disp_req/x/y          display fetch request and coordinates
//   disp_valid/data/stale display result (stale = repeat of last value)
//   col_req/x/y           probe request, held stable until col_ack
//   col_ack               combinational: probe accepted this cycle
//   col_valid/data        probe result, one-cycle pulse
//   ram_read_address      registered RAM read address
//   ram_data_Out          RAM read data (registered inside the RAM)
module bg_read_arbiter #(
    parameter int          WIDTH        = 480,
    parameter int          HEIGHT       = 270,
    parameter int          STARVE_LIMIT = 8,
    parameter logic [3:0]  OOB_VALUE    = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        disp_req,
    input  logic [9:0]  disp_x,
    input  logic [9:0]  disp_y,
    output logic        disp_valid,
    output logic [3:0]  disp_data,
    output logic        disp_stale,
    input  logic        col_req,
    input  logic [9:0]  col_x,
    input  logic [9:0]  col_y,
    output logic        col_ack,
    output logic        col_valid,
    output logic [3:0]  col_data,
    output logic [16:0] ram_read_address,
    input  logic [3:0]  ram_data_Out
);

    localparam int WCW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT - 1);

    // Both owners can be in flight in the same slot (forced probe plus the
    // displaced display request), so the tag carries one valid per owner.
    typedef struct packed {
        logic d_vld;
        logic d_oob;
        logic d_stale;
        logic c_vld;
        logic c_oob;
    } tag_t;

    logic [16:0]    addr_q, addr_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    tag_t           tag1_q, tag1_d, tag2_q;
    logic [3:0]     last_disp_q;
    logic [3:0]     disp_hold_q, col_hold_q;

    logic        forced, col_grant, disp_grant;
    logic        disp_inr, col_inr;
    logic [16:0] disp_addr, col_addr;
    logic [3:0]  disp_val, col_val;

    always_comb begin
        disp_addr = 17'(disp_y) * 17'(WIDTH) + 17'(disp_x);
        col_addr  = 17'(col_y) * 17'(WIDTH) + 17'(col_x);
        disp_inr  = (32'(disp_x) < WIDTH) && (32'(disp_y) < HEIGHT);
        col_inr   = (32'(col_x) < WIDTH) && (32'(col_y) < HEIGHT);

        forced     = col_req && (wait_cnt_q == WAIT_MAX);
        col_grant  = !Reset && col_req && (forced || !disp_req);
        // A display request always gets a slot; if the probe took the port
        // it is answered from the last-display-data register instead.
        disp_grant = !Reset && disp_req;
        col_ack    = col_grant;

        tag1_d.d_vld   = disp_grant;
        tag1_d.d_stale = disp_grant && col_grant;
        tag1_d.d_oob   = disp_grant && !col_grant && !disp_inr;
        tag1_d.c_vld   = col_grant;
        tag1_d.c_oob   = col_grant && !col_inr;

        // Out-of-range and idle cycles leave the address untouched.
        addr_d = addr_q;
        if (col_grant) begin
            if (col_inr) addr_d = col_addr;
        end else if (disp_grant && disp_inr) begin
            addr_d = disp_addr;
        end

        if (!col_req || col_grant) wait_cnt_d = '0;
        else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
        else wait_cnt_d = wait_cnt_q;

        disp_val = tag2_q.d_stale ? last_disp_q :
                   tag2_q.d_oob   ? OOB_VALUE   : ram_data_Out;
        col_val  = tag2_q.c_oob   ? OOB_VALUE   : ram_data_Out;

        disp_valid = !Reset && tag2_q.d_vld;
        disp_stale = disp_valid && tag2_q.d_stale;
        col_valid  = !Reset && tag2_q.c_vld;
        disp_data  = Reset ? 4'h0 : (disp_valid ? disp_val : disp_hold_q);
        col_data   = Reset ? 4'h0 : (col_valid ? col_val : col_hold_q);
    end

    assign ram_read_address = addr_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q      <= '0;
            wait_cnt_q  <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            last_disp_q <= '0;
            disp_hold_q <= '0;
            col_hold_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            if (disp_valid) begin
                disp_hold_q <= disp_data;
                if (!disp_stale) last_disp_q <= disp_data;
            end
            if (col_valid) col_hold_q <= col_data;
        end
    end

endmodule

// File: tb/tb_bg_read_arbiter.sv
module tb_bg_read_arbiter;

    localparam int W = 480;
    localparam int H = 270;
    localparam int LIM = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        disp_req;
    logic [9:0]  disp_x, disp_y;
    logic        disp_valid, disp_stale;
    logic [3:0]  disp_data;
    logic        col_req;
    logic [9:0]  col_x, col_y;
    logic        col_ack, col_valid;
    logic [3:0]  col_data;
    logic [16:0] ram_read_address;
    logic [3:0]  ram_data_Out;

    bg_read_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_stale(disp_stale),
        .col_req(col_req), .col_x(col_x), .col_y(col_y),
        .col_ack(col_ack), .col_valid(col_valid), .col_data(col_data),
        .ram_read_address(ram_read_address), .ram_data_Out(ram_data_Out)
    );

    always #5 Clk = ~Clk;

    // RAM: contents addr mod 16, registered read.
    logic [3:0] mem [0:W*H-1];
    initial for (int i = 0; i < W*H; i++) mem[i] = 4'(i % 16);
    always @(posedge Clk) ram_data_Out <= mem[ram_read_address];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: results scheduled by cycle number.
    int  cyc = 0;
    bit  edv [0:4095];
    bit  eds [0:4095];
    int  edd [0:4095];
    bit  ecv [0:4095];
    int  ecd [0:4095];
    int  m_addr = 0, m_wait = 0, m_last = 0, m_dh = 0, m_ch = 0;
    bit  got_ack = 0;

    function automatic bit inr(input int x, input int y);
        return (x < W) && (y < H);
    endfunction

    task automatic model_step();
        int  c = cyc;
        bit  forced, cg, dg;
        int  v;
        chk("ram_read_address", ram_read_address, m_addr);
        if (Reset) begin
            chk("rst_col_ack", col_ack, 0);
            chk("rst_disp_valid", disp_valid, 0);
            chk("rst_disp_data", disp_data, 0);
            chk("rst_disp_stale", disp_stale, 0);
            chk("rst_col_valid", col_valid, 0);
            chk("rst_col_data", col_data, 0);
            for (int k = 1; k <= 2; k++) begin
                edv[c+k] = 0; ecv[c+k] = 0;
            end
            m_addr = 0; m_wait = 0; m_last = 0; m_dh = 0; m_ch = 0;
            got_ack = 0;
        end else begin
            forced = col_req && (m_wait == LIM-1);
            cg = col_req && (forced || !disp_req);
            dg = disp_req;
            got_ack = cg;
            chk("col_ack", col_ack, cg);
            chk("disp_valid", disp_valid, edv[c]);
            chk("disp_stale", disp_stale, edv[c] && eds[c]);
            chk("disp_data", disp_data, edv[c] ? edd[c] : m_dh);
            chk("col_valid", col_valid, ecv[c]);
            chk("col_data", col_data, ecv[c] ? ecd[c] : m_ch);
            if (edv[c]) m_dh = edd[c];
            if (ecv[c]) m_ch = ecd[c];
            if (cg) begin
                if (inr(col_x, col_y)) begin
                    m_addr = col_y * W + col_x;
                    v = m_addr % 16;
                end else v = 0;
                ecv[c+2] = 1; ecd[c+2] = v;
            end
            if (dg) begin
                edv[c+2] = 1;
                if (cg) begin
                    eds[c+2] = 1; edd[c+2] = m_last;
                end else begin
                    if (inr(disp_x, disp_y)) begin
                        m_addr = disp_y * W + disp_x;
                        v = m_addr % 16;
                    end else v = 0;
                    eds[c+2] = 0; edd[c+2] = v; m_last = v;
                end
            end
            m_wait = (col_req && !cg) ? ((m_wait < LIM-1) ? m_wait + 1 : m_wait) : 0;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge Clk);
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic setd(input bit r, input int x, input int y);
        disp_req = r; disp_x = 10'(x); disp_y = 10'(y);
    endtask

    task automatic setc(input bit r, input int x, input int y);
        col_req = r; col_x = 10'(x); col_y = 10'(y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1; setd(0, 0, 0); setc(0, 0, 0);
        tick(); tick();
        Reset = 0;
        tick();

        // Display stream
        setd(1, 0, 0);   tick();
        setd(1, 1, 0);   tick();
        chk("stream0_v", disp_valid, 1); chk("stream0_d", disp_data, 0);
        setd(1, 479, 0); tick();
        chk("stream1_d", disp_data, 1);
        setd(1, 0, 1);   tick();
        chk("stream2_d", disp_data, 15);
        setd(0, 0, 0);   tick();
        chk("stream3_d", disp_data, 0); chk("stream3_s", disp_stale, 0);
        tick(); tick();

        // Probe in blanking
        setc(1, 10, 2); #1;
        chk("blank_ack", col_ack, 1);
        tick();
        setc(0, 0, 0);
        chk("blank_addr", ram_read_address, 970);
        tick();
        chk("blank_cv", col_valid, 1); chk("blank_cd", col_data, 10);
        tick();

        // Starvation
        setd(1, 7, 0); tick(); tick();
        setc(1, 5, 5);
        for (int i = 0; i < LIM-1; i++) begin
            #1 chk("starve_noack", col_ack, 0);
            tick();
        end
        #1 chk("starve_forced_ack", col_ack, 1);
        tick();
        setc(0, 0, 0);
        tick();
        chk("starve_cv", col_valid, 1);  chk("starve_cd", col_data, 5);
        chk("starve_dv", disp_valid, 1); chk("starve_ds", disp_stale, 1);
        chk("starve_dd", disp_data, 7);
        chk("starve_wait", dut.wait_cnt_q, 0);

        // Out of range
        setd(1, 480, 0); tick();
        setd(0, 0, 0); setc(1, 0, 270); #1;
        chk("oob_ack", col_ack, 1);
        tick();
        setc(0, 0, 0);
        chk("oob_dv", disp_valid, 1); chk("oob_dd", disp_data, 0);
        chk("oob_addr0", ram_read_address, 7);
        tick();
        chk("oob_cv", col_valid, 1); chk("oob_cd", col_data, 0);
        chk("oob_addr1", ram_read_address, 7);
        tick(); tick();

        // Reset mid-flight
        setd(1, 1, 1); tick();
        setd(0, 0, 0); setc(1, 2, 2); tick();
        Reset = 1; setd(1, 3, 0); setc(1, 3, 3); #1;
        chk("rstmid_ack", col_ack, 0);
        tick();
        Reset = 0; setd(0, 0, 0); setc(0, 0, 0);
        chk("rstmid_dv2", disp_valid, 0); chk("rstmid_cv2", col_valid, 0);
        chk("rstmid_addr", ram_read_address, 0);
        tick();
        chk("rstmid_dv3", disp_valid, 0); chk("rstmid_cv3", col_valid, 0);
        setd(1, 1, 0); tick();
        setd(0, 0, 0); tick();
        chk("rstmid_first_v", disp_valid, 1); chk("rstmid_first_d", disp_data, 1);
        tick();

        // Simultaneous, not forced
        setd(1, 2, 0); setc(1, 3, 0); #1;
        chk("simul_ack", col_ack, 0);
        tick();
        chk("simul_wait", dut.wait_cnt_q, 1);
        setd(0, 0, 0); #1;
        chk("simul_ack2", col_ack, 1);
        tick();
        setc(0, 0, 0); tick();
        chk("simul_cd", col_data, 3);
        tick(); tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            Reset = ($urandom_range(0, 149) == 0);
            setd($urandom_range(0, 99) < 80, $urandom_range(0, 499), $urandom_range(0, 279));
            if (!col_req || got_ack)
                setc($urandom_range(0, 2) != 0, $urandom_range(0, 499), $urandom_range(0, 279));
            else if ($urandom_range(0, 29) == 0)
                col_req = 0;
            tick();
        end
        Reset = 0; setd(0, 0, 0); setc(0, 0, 0);
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
